// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM port controller.
// Optional CLEAR state is compiled in with SRAM_PORT_CLEAR_EN.
package sram_ctrl_pkg;

  localparam int unsigned AW_DEF          = 32'd11;
  localparam int unsigned DW_DEF          = 32'd32;
  localparam int unsigned IDLE_CYCLES_DEF = 32'd16;
  localparam int unsigned WAKE_CYCLES_DEF = 32'd2;
  localparam int unsigned RSP_DEPTH_DEF   = 32'd2;

  typedef enum logic [1:0] {
    SLEEP  = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
`ifdef SRAM_PORT_CLEAR_EN
    , CLEAR = 2'd3
`endif
  } state_e;

  // Bits needed to hold a count of 0..max_val-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 32'd2) ? 32'd1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO: RSP_DEPTH entries, power-of-two depth, occupancy output.
// The caller guarantees no push when full and no pop when empty.
module sram_rsp_fifo #(
  parameter int unsigned DW    = 32'd32,
  parameter int unsigned DEPTH = 32'd2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 32'd1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      count_q <= count_q + {{(CW-1){1'b0}}, push_i} - {{(CW-1){1'b0}}, pop_i};
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// One-port initiator controller for the 2048x32 dual-port SRAM macro: request
// strobes, response FIFO, idle standby. SRAM_PORT_CLEAR_EN adds a zero-fill sweep.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int unsigned RSP_DEPTH   = RSP_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          sram_csn,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q,
  output logic          sram_stdby,
`ifdef SRAM_PORT_CLEAR_EN
  input  logic          clr_start,
  output logic          clr_done,
`endif
  output logic          busy
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 32'd1;
  localparam int unsigned IW = cnt_width(IDLE_CYCLES);
  localparam int unsigned WW = cnt_width(WAKE_CYCLES);

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [WW-1:0] wake_q, wake_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q;
  logic          hs_s, drv_s, wen_s, stdby_s, clr_go_s;
  logic [AW-1:0] a_s;
  logic [DW-1:0] d_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   occ_s;
  logic          pop_s, rd_room_s;
`ifdef SRAM_PORT_CLEAR_EN
  logic          clr_pend_q, clr_pend_d;
  logic          clr_done_q, clr_done_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
`endif

  // Reset synchronizer: asserts immediately, releases two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

`ifdef SRAM_PORT_CLEAR_EN
  assign clr_go_s = clr_start;
`else
  assign clr_go_s = 1'b0;
`endif

  // Counting already-committed reads keeps the FIFO from ever being oversubscribed.
  assign rsp_valid = (fifo_count_s != {CW{1'b0}});
  assign pop_s     = rsp_valid & rsp_ready;
  assign occ_s     = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
  assign rd_room_s = (occ_s < (CW+1)'(RSP_DEPTH));

  // Next-state, request acceptance and macro strobe selection.
  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    wake_d     = wake_q;
    req_ready  = 1'b0;
    hs_s       = 1'b0;
    drv_s      = 1'b0;
    wen_s      = 1'b1;
    stdby_s    = 1'b0;
    a_s        = a_q;
    d_s        = d_q;
`ifdef SRAM_PORT_CLEAR_EN
    clr_pend_d = clr_pend_q;
    clr_done_d = 1'b0;
    clr_addr_d = clr_addr_q;
`endif
    case (state_q)
      SLEEP: begin
        stdby_s = 1'b1;
        idle_d  = {IW{1'b0}};
        wake_d  = {WW{1'b0}};
        if (req_valid || clr_go_s) begin
          state_d = WAKE;
        end else begin
          state_d = SLEEP;
        end
`ifdef SRAM_PORT_CLEAR_EN
        if (clr_start) begin
          clr_pend_d = 1'b1;
        end else begin
          clr_pend_d = clr_pend_q;
        end
`endif
      end
      WAKE: begin
        if (wake_q == WW'(WAKE_CYCLES - 32'd1)) begin
          wake_d = {WW{1'b0}};
`ifdef SRAM_PORT_CLEAR_EN
          state_d    = clr_pend_q ? CLEAR : ACTIVE;
          clr_addr_d = {AW{1'b0}};
`else
          state_d = ACTIVE;
`endif
        end else begin
          wake_d = wake_q + {{(WW-1){1'b0}}, 1'b1};
        end
      end
      ACTIVE: begin
        if (clr_go_s) begin
          idle_d = {IW{1'b0}};
`ifdef SRAM_PORT_CLEAR_EN
          state_d    = CLEAR;
          clr_addr_d = {AW{1'b0}};
`endif
        end else begin
          req_ready = req_we | rd_room_s;
          hs_s      = req_valid & req_ready;
          if (hs_s) begin
            drv_s = 1'b1;
            wen_s = ~req_we;
            a_s   = req_addr;
            d_s   = req_wdata;
          end else begin
            drv_s = 1'b0;
          end
          // A request arriving on the expiry cycle is a handshake, so it wins over sleep.
          if (!hs_s && !inflight_q && !rsp_valid) begin
            if (idle_q == IW'(IDLE_CYCLES - 32'd1)) begin
              idle_d  = {IW{1'b0}};
              state_d = SLEEP;
            end else begin
              idle_d = idle_q + {{(IW-1){1'b0}}, 1'b1};
            end
          end else begin
            idle_d = {IW{1'b0}};
          end
        end
      end
`ifdef SRAM_PORT_CLEAR_EN
      CLEAR: begin
        drv_s      = 1'b1;
        wen_s      = 1'b0;
        a_s        = clr_addr_q;
        d_s        = {DW{1'b0}};
        idle_d     = {IW{1'b0}};
        clr_addr_d = clr_addr_q + {{(AW-1){1'b0}}, 1'b1};
        if (clr_addr_q == {AW{1'b1}}) begin
          state_d    = ACTIVE;
          clr_done_d = 1'b1;
          clr_pend_d = 1'b0;
        end else begin
          state_d = CLEAR;
        end
      end
`endif
      default: begin
        state_d = SLEEP;
      end
    endcase
  end

  assign inflight_d = hs_s & ~req_we;

  // Control state; A/D registers hold the macro pins steady between accesses.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= SLEEP;
      idle_q     <= {IW{1'b0}};
      wake_q     <= {WW{1'b0}};
      inflight_q <= 1'b0;
      a_q        <= {AW{1'b0}};
      d_q        <= {DW{1'b0}};
`ifdef SRAM_PORT_CLEAR_EN
      clr_pend_q <= 1'b0;
      clr_done_q <= 1'b0;
      clr_addr_q <= {AW{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      wake_q     <= wake_d;
      inflight_q <= inflight_d;
      a_q        <= a_s;
      d_q        <= d_s;
`ifdef SRAM_PORT_CLEAR_EN
      clr_pend_q <= clr_pend_d;
      clr_done_q <= clr_done_d;
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  sram_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_int_n),
    .push_i  (inflight_q),
    .wdata_i (sram_q),
    .pop_i   (pop_s),
    .rdata_o (rsp_rdata),
    .count_o (fifo_count_s)
  );

  assign sram_csn   = ~drv_s;
  assign sram_wen   = wen_s;
  assign sram_a     = a_s;
  assign sram_d     = d_s;
  assign sram_stdby = stdby_s;
  assign busy       = (state_q != SLEEP) | inflight_q | rsp_valid;
`ifdef SRAM_PORT_CLEAR_EN
  assign clr_done   = clr_done_q;
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Scoreboard bench for sram_port_ctrl with a behavioural 2048x32 macro model.
// Build with SRAM_PORT_CLEAR_EN to also exercise the zero-fill sweep.
module tb_sram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        sram_csn, sram_wen, sram_stdby, busy;
  logic [10:0] sram_a;
  logic [31:0] sram_d, sram_q;
`ifdef SRAM_PORT_CLEAR_EN
  logic        clr_start, clr_done;
`endif

  always #5 clk = ~clk;

  sram_port_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_csn   (sram_csn),
    .sram_wen   (sram_wen),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q),
    .sram_stdby (sram_stdby),
`ifdef SRAM_PORT_CLEAR_EN
    .clr_start  (clr_start),
    .clr_done   (clr_done),
`endif
    .busy       (busy)
  );

  // Macro model: Q updates on a read edge and holds otherwise.
  logic [31:0] mem [2048];
  logic [31:0] q_r = 32'h0;
  always @(posedge clk) begin
    if (!sram_csn) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           q_r <= mem[sram_a];
    end
  end
  assign sram_q = q_r;

  typedef struct { logic [31:0] data; int min_cyc; } exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] shadow [2048];
  int passed = 0, total = 0, cyc = 0;
  int pops = 0, last_pop_cyc = -1, rsp_seen = 0, csn_lo = 0, wr_zero = 0, done_cnt = 0;
  int last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever a response is consumed.
  always @(negedge clk) begin
    if (!sram_csn) csn_lo++;
    if (!sram_csn && !sram_wen && sram_d == 32'h0) wr_zero++;
    if (rsp_valid) rsp_seen++;
`ifdef SRAM_PORT_CLEAR_EN
    if (clr_done) done_cnt++;
`endif
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp: got 0x%08h, required no response", rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", rsp_rdata, mon_e.data);
        total++;
        if (cyc >= mon_e.min_cyc) passed++;
        else $display("FAIL rsp_latency: got cycle %0d, required >= %0d", cyc, mon_e.min_cyc);
      end
      pops++;
      last_pop_cyc = cyc;
    end
  end

  // Issue one request; entered and left at posedge+1. waited = stall cycles.
  task automatic send(input logic we, input logic [10:0] a, input logic [31:0] d, output int waited);
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; waited = 0;
    #1;
    while (!req_ready && waited < 200) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!req_ready) begin
      total++;
      $display("FAIL send_timeout: req_ready 0 for 200 cycles, required 1 (addr 0x%03h)", a);
    end else begin
      if (we) shadow[a] = d;
      else begin
        e.data = shadow[a]; e.min_cyc = cyc + 2;
        exp_q.push_back(e);
      end
      last_acc_cyc = cyc;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stalls, first_acc, rd_acc, p0, c0, s0, rhi;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 11'h0;
    req_wdata = 32'h0; rsp_ready = 1'b0;
`ifdef SRAM_PORT_CLEAR_EN
    clr_start = 1'b0;
`endif
    repeat (3) @(posedge clk); #1;
    check("rst_stdby", 32'(sram_stdby), 32'd1);
    check("rst_csn", 32'(sram_csn), 32'd1);
    check("rst_wen", 32'(sram_wen), 32'd1);
    check("rst_a", 32'(sram_a), 32'd0);
    check("rst_d", sram_d, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("sleep_hold_stdby", 32'(sram_stdby), 32'd1);

    // 1: write then read the top address.
    rsp_ready = 1'b1;
    c0 = csn_lo;
    send(1'b1, 11'h7FF, 32'hDEADBEEF, w);
    send(1'b0, 11'h7FF, 32'h5555_5555, w);
    rd_acc = last_acc_cyc;
    wait_drain();
    check("t1_csn_cycles", 32'(csn_lo - c0), 32'd2);
    check("t1_latency", 32'(last_pop_cyc - rd_acc), 32'd2);

    // 2: back-to-back reads of 0..7.
    for (int i = 0; i < 8; i++) send(1'b1, 11'(i), 32'hC0DE_0000 + 32'(i) * 32'h111, w);
    stalls = 0; p0 = pops;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 11'(i), 32'h0, w);
      if (i == 0) first_acc = last_acc_cyc;
      stalls += w;
    end
    wait_drain();
    check("t2_stalls", 32'(stalls), 32'd0);
    check("t2_accept_span", 32'(last_acc_cyc - first_acc), 32'd7);
    check("t2_rsp_count", 32'(pops - p0), 32'd8);
    check("t2_last_latency", 32'(last_pop_cyc - last_acc_cyc), 32'd2);

    // 3: backpressure limits outstanding reads to the FIFO depth.
    rsp_ready = 1'b0; p0 = pops;
    send(1'b0, 11'h7FF, 32'h0, w);
    send(1'b0, 11'h003, 32'h0, w);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h005; rhi = 0;
    repeat (5) begin
      @(posedge clk); #2;
      if (req_ready) rhi++;
    end
    check("t3_ready_while_full", 32'(rhi), 32'd0);
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_no_pop", 32'(pops - p0), 32'd0);
    rsp_ready = 1'b1;
    send(1'b0, 11'h005, 32'h0, w);
    wait_drain();
    check("t3_rsp_count", 32'(pops - p0), 32'd3);

    // 4: idle entry to standby, then wake latency.
    send(1'b1, 11'h100, 32'h1234_5678, w);
    repeat (15) @(posedge clk); #1;
    check("t4_stdby_cycle16", 32'(sram_stdby), 32'd0);
    @(posedge clk); #1;
    check("t4_stdby_cycle17", 32'(sram_stdby), 32'd1);
    check("t4_busy_asleep", 32'(busy), 32'd0);
    send(1'b0, 11'h100, 32'h0, w);
    check("t4_wake_wait", 32'(w), 32'd3);
    wait_drain();

    // 5: reset with a read in flight.
    send(1'b0, 11'h7FF, 32'h5555_5555, w);
    rst_n = 1'b0;
    #1;
    check("t5_csn", 32'(sram_csn), 32'd1);
    check("t5_stdby", 32'(sram_stdby), 32'd1);
    check("t5_ready", 32'(req_ready), 32'd0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_a", 32'(sram_a), 32'd0);
    check("t5_d", sram_d, 32'd0);
    exp_q.delete();
    s0 = rsp_seen;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    check("t5_no_rsp_after", 32'(rsp_seen - s0), 32'd0);

`ifdef SRAM_PORT_CLEAR_EN
    // 6: zero-fill sweep from sleep, then read back.
    c0 = wr_zero;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    w = 0;
    while (done_cnt == 0 && w < 2200) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (5) @(posedge clk); #1;
    check("t6_done_pulses", 32'(done_cnt), 32'd1);
    check("t6_zero_writes", 32'(wr_zero - c0), 32'd2048);
    for (int i = 0; i < 2048; i++) shadow[i] = 32'h0;
    send(1'b0, 11'h7FF, 32'h0, w);
    send(1'b0, 11'h003, 32'h0, w);
    send(1'b0, 11'h100, 32'h0, w);
    wait_drain();
`endif

    wait_drain();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
Name: sram_port_ctrl

Overview:
- Initiator-side controller for one port of the 2048x32 dual-port SRAM macro. It converts a valid/ready request stream into the macro's CSN/WEN/A/D strobes.
- It captures the macro's Q output into a response FIFO with backpressure.
- It manages standby entry and exit on idle.
- One instance drives each macro port. The test pins (TBIST, TBYPASS, SE, ATP, etc.) are tied off in the wrapper, not here.

Parameters:
- AW, 11, SRAM address width (2048 words).
- DW, 32, SRAM data width.
- IDLE_CYCLES, 16, consecutive idle cycles before standby is asserted (must be ≥1).
- WAKE_CYCLES, 2, cycles STDBY must be low before the first access after standby.
- RSP_DEPTH, 2, response FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  single clock, also drives macro CK.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready at a rising edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts rsp_rdata.
- rsp_rdata  out  DW  read data, in request order.
- sram_csn  out  1  macro CSN (active low).
- sram_wen  out  1  macro WEN (0 = write).
- sram_a  out  AW  macro A.
- sram_d  out  DW  macro D.
- sram_q  in  DW  macro Q, valid in the cycle after a read edge.
- sram_stdby  out  1  macro STDBY.
- busy  out  1  high when not in SLEEP, or when a read is in flight / the FIFO is non-empty.

Behaviour:
- Reset values: state = SLEEP, sram_stdby = 1, sram_csn = 1, sram_wen = 1, sram_a = 0, sram_d = 0, req_ready = 0, rsp_valid = 0, FIFO empty, counters = 0.
- Reset is asserted asynchronously and released synchronously through the 2-flop synchronizer used for every other reset in the design. Reset mid-operation discards the in-flight read and FIFO contents.
- States:
  - SLEEP: sram_stdby = 1, req_ready = 0. A req_valid moves the block to WAKE.
  - WAKE: sram_stdby = 0, req_ready = 0. The wake counter counts WAKE_CYCLES, then the block moves to ACTIVE.
  - ACTIVE: sram_stdby = 0. Requests are served here.
- Request path in ACTIVE:
  - Macro signals are combinational from the request: sram_csn = ~(req_valid & req_ready), sram_wen = ~req_we, sram_a = req_addr, sram_d = req_wdata.
  - When no request is accepted, sram_csn = 1 and A/D hold their last values (no toggling).
- Write: one cycle, no response.
- Read, accepted at edge E:
  - sram_q is captured into the FIFO at edge E+1.
  - rsp_valid is high from the cycle after E+1 at the earliest (2-cycle latency).
  - The FIFO is not bypassed.
- Read flow control:
  - req_ready for a read = (fifo_count + inflight − pop) < RSP_DEPTH, where pop = rsp_valid & rsp_ready in the same cycle.
  - Writes are always ready in ACTIVE.
  - With rsp_ready held high, back-to-back reads sustain 1 per cycle.
  - No read data is ever dropped; the FIFO never overflows.
- Idle counter:
  - Counts ACTIVE cycles with no handshake, no inflight read and an empty FIFO; any other cycle clears it.
  - On reaching IDLE_CYCLES the block enters SLEEP.
  - If req_valid is high on that same cycle, the request is accepted (ready = 1) and the idle counter is cleared instead.
- Simultaneous FIFO push and pop: count is unchanged; push at full is impossible by construction.
- Address wrap-around is the caller's responsibility; the address is passed through unchanged.

Optional Feature:
- SRAM_PORT_CLEAR_EN: adds input clr_start and output clr_done.
- With the macro defined:
  - A pulse on clr_start in ACTIVE or SLEEP enters CLEAR, waking first if asleep.
  - CLEAR writes 0 to addresses 0..2^AW−1, one per cycle, with req_ready = 0.
  - clr_done pulses for 1 cycle after the write to the last address, then the block returns to ACTIVE.
  - clr_start during CLEAR is ignored.
- Without the macro: no ports are added and no CLEAR state exists.

Decomposition:
- Package sram_ctrl_pkg: state enum (SLEEP, WAKE, ACTIVE, CLEAR), AW/DW defaults, idle and wake constants.
- Sub-module sram_rsp_fifo: synchronous FIFO of RSP_DEPTH entries with count output, push/pop.

Test Plan:
1. After reset, write 0xDEADBEEF to address 0x7FF, then read 0x7FF → sram_csn low for 2 cycles; rsp_rdata = 0xDEADBEEF 2 cycles after read accept.
2. Eight back-to-back reads of addresses 0..7 with rsp_ready = 1 → req_ready stays high; 8 responses arrive in order, one per cycle.
3. Reads issued with rsp_ready = 0 → exactly 2 accepted, then req_ready = 0. Releasing rsp_ready → data returned in order, none lost.
4. Idle for 16 cycles → sram_stdby = 1 on cycle 17. Then req_valid → 2 WAKE cycles, request accepted on cycle 3.
5. Reset asserted while a read is in flight → all outputs return to reset values immediately; no rsp_valid after release.
6. With SRAM_PORT_CLEAR_EN defined: clr_start → 2048 writes of 0, clr_done pulses once; subsequent reads return 0.
